// File: rtl/move_controller.sv
// move_controller: two-click chess move sequencer.
// Holds the 8x8 board and the side to move. It feeds the selected piece to
// the external move-mask generator, removes own-colour squares from the
// returned mask, commits legal moves (with pawn promotion) and stops the
// game when a king is captured.
module move_controller (
    input  logic         clk,
    input  logic         rst,
    input  logic         new_game,
    input  logic         click_valid,
    input  logic [5:0]   click_pos,
    output logic [3:0]   ml_figure,
    output logic [5:0]   ml_position,
    input  logic [63:0]  ml_moves,
    output logic [255:0] board_flat,
    output logic         turn,
    output logic         selected,
    output logic [5:0]   sel_pos,
    output logic [63:0]  hl_mask,
    output logic         move_done,
    output logic         err,
    output logic         game_over,
    output logic         winner
);

    typedef enum logic [2:0] {
        WAIT_SRC  = 3'd0,
        EVAL      = 3'd1,
        WAIT_DST  = 3'd2,
        COMMIT    = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    // Piece codes used by the sequencing logic
    localparam logic [3:0] W_PAWN  = 4'd1;
    localparam logic [3:0] W_QUEEN = 4'd5;
    localparam logic [3:0] W_KING  = 4'd6;
    localparam logic [3:0] B_PAWN  = 4'd7;
    localparam logic [3:0] B_QUEEN = 4'd11;
    localparam logic [3:0] B_KING  = 4'd12;

    state_t      state_q;
    logic [3:0]  board_q [64];
    logic        turn_q;
    logic        selected_q;
    logic [5:0]  sel_pos_q;
    logic [3:0]  src_fig_q;
    logic [5:0]  dst_q;
    logic [63:0] hl_mask_q;
    logic        move_done_q;
    logic        err_q;
    logic        game_over_q;
    logic        winner_q;

    logic [63:0] own_mask;
    logic        click_own;
    logic [3:0]  dst_old_d;
    logic [3:0]  dst_fig_d;

    // Start-position code of one square
    function automatic logic [3:0] start_code(input logic [5:0] idx);
        logic [3:0] code;
        code = 4'd0;
        case (idx[5:3])
            3'd0: begin
                case (idx[2:0])
                    3'd0, 3'd7: code = 4'd4;
                    3'd1, 3'd6: code = 4'd3;
                    3'd2, 3'd5: code = 4'd2;
                    3'd3:       code = 4'd5;
                    default:    code = 4'd6;
                endcase
            end
            3'd1:    code = W_PAWN;
            3'd6:    code = B_PAWN;
            3'd7: begin
                case (idx[2:0])
                    3'd0, 3'd7: code = 4'd10;
                    3'd1, 3'd6: code = 4'd9;
                    3'd2, 3'd5: code = 4'd8;
                    3'd3:       code = 4'd11;
                    default:    code = 4'd12;
                endcase
            end
            default: code = 4'd0;
        endcase
        return code;
    endfunction

    // True when the code belongs to the side to move
    function automatic logic is_own(input logic [3:0] code, input logic side);
        if (side)
            return (code >= B_PAWN) && (code <= B_KING);
        else
            return (code >= W_PAWN) && (code <= W_KING);
    endfunction

    // Per-square own-colour mask and board flattening
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_square
            assign own_mask[gi]               = is_own(board_q[gi], turn_q);
            assign board_flat[gi*4 +: 4]      = board_q[gi];
        end
    endgenerate

    assign click_own = own_mask[click_pos];
    assign dst_old_d = board_q[dst_q];

    // Figure written at the destination, with promotion on the far rank
    always_comb begin
        dst_fig_d = src_fig_q;
        if (src_fig_q == W_PAWN && dst_q[5:3] == 3'd7)
            dst_fig_d = W_QUEEN;
        else if (src_fig_q == B_PAWN && dst_q[5:3] == 3'd0)
            dst_fig_d = B_QUEEN;
    end

    // Mask-generator request is only live while a selection is being handled
    always_comb begin
        ml_figure   = 4'd0;
        ml_position = 6'd0;
        if (state_q == EVAL || state_q == WAIT_DST || state_q == COMMIT) begin
            ml_figure   = src_fig_q;
            ml_position = sel_pos_q;
        end
    end

    // Main game-flow FSM including board storage; new_game overrides everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WAIT_SRC;
            for (int i = 0; i < 64; i++) board_q[i] <= start_code(6'(i));
            turn_q      <= 1'b0;
            selected_q  <= 1'b0;
            sel_pos_q   <= 6'd0;
            src_fig_q   <= 4'd0;
            dst_q       <= 6'd0;
            hl_mask_q   <= 64'd0;
            move_done_q <= 1'b0;
            err_q       <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
        end else begin
            move_done_q <= 1'b0;
            err_q       <= 1'b0;
            if (new_game) begin
                state_q     <= WAIT_SRC;
                for (int i = 0; i < 64; i++) board_q[i] <= start_code(6'(i));
                turn_q      <= 1'b0;
                selected_q  <= 1'b0;
                sel_pos_q   <= 6'd0;
                src_fig_q   <= 4'd0;
                hl_mask_q   <= 64'd0;
                game_over_q <= 1'b0;
                winner_q    <= 1'b0;
            end else begin
                case (state_q)
                    WAIT_SRC: begin
                        if (click_valid) begin
                            if (click_own) begin
                                sel_pos_q  <= click_pos;
                                src_fig_q  <= board_q[click_pos];
                                selected_q <= 1'b1;
                                state_q    <= EVAL;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    EVAL: begin
                        hl_mask_q <= ml_moves & ~own_mask;
                        if ((ml_moves & ~own_mask) == 64'd0) begin
                            err_q      <= 1'b1;
                            selected_q <= 1'b0;
                            state_q    <= WAIT_SRC;
                        end else begin
                            state_q <= WAIT_DST;
                        end
                    end
                    WAIT_DST: begin
                        if (click_valid) begin
                            if (click_pos == sel_pos_q) begin
                                selected_q <= 1'b0;
                                hl_mask_q  <= 64'd0;
                                state_q    <= WAIT_SRC;
                            end else if (click_own) begin
                                sel_pos_q <= click_pos;
                                src_fig_q <= board_q[click_pos];
                                state_q   <= EVAL;
                            end else if (hl_mask_q[click_pos]) begin
                                dst_q   <= click_pos;
                                state_q <= COMMIT;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    COMMIT: begin
                        board_q[dst_q]     <= dst_fig_d;
                        board_q[sel_pos_q] <= 4'd0;
                        selected_q         <= 1'b0;
                        hl_mask_q          <= 64'd0;
                        move_done_q        <= 1'b1;
                        if (dst_old_d == W_KING || dst_old_d == B_KING) begin
                            game_over_q <= 1'b1;
                            winner_q    <= turn_q;
                            state_q     <= GAME_OVER;
                        end else begin
                            turn_q  <= ~turn_q;
                            state_q <= WAIT_SRC;
                        end
                    end
                    GAME_OVER: begin
                        state_q <= GAME_OVER;
                    end
                    default: begin
                        state_q <= WAIT_SRC;
                    end
                endcase
            end
        end
    end

    assign turn      = turn_q;
    assign selected  = selected_q;
    assign sel_pos   = sel_pos_q;
    assign hl_mask   = hl_mask_q;
    assign move_done = move_done_q;
    assign err       = err_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule
